ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (index 0 = cpu0 I, 1 = cpu0 D, 2 = cpu1 I, 3 = cpu1 D).
REQ-002 Parameter TIMEOUT_CYCLES, default 64, BUSY-state watchdog limit.
REQ-003 CLK  in  1  sole clock, all state updates on rising edge.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 req_ren  in  NREQ  per-requester read request.
REQ-006 req_wen  in  NREQ  per-requester write request.
REQ-007 req_addr  in  NREQ x word_t  per-requester address.
REQ-008 req_store  in  NREQ x word_t  per-requester write data.
REQ-009 req_wait  out  NREQ  per-requester wait; 0 means access complete this cycle.
REQ-010 req_load  out  word_t  read data, valid for the requester whose req_wait is 0.
REQ-011 ramaddr, ramstore  out  word_t  RAM address and write data.
REQ-012 ramREN, ramWEN  out  1  RAM read and write enables.
REQ-013 ramload  in  word_t  RAM read data.
REQ-014 ramstate  in  ramstate_t  RAM status: FREE, BUSY, ACCESS, ERROR.
REQ-015 err_illegal, err_ram, err_timeout  out  1  one-cycle error pulses.

Function
REQ-016 Eligibility: a requester is eligible when exactly one of req_ren[i] and req_wen[i] is high; when both are high the requester is ineligible and err_illegal pulses every cycle that condition holds.
REQ-017 Arbitration: round-robin starting at index ptr; the first eligible index at or after ptr, with wrap from NREQ-1 to 0, wins; ptr resets to 0.
REQ-018 FSM states IDLE and BUSY.
REQ-019 IDLE: ramREN=ramWEN=0, ramaddr=ramstore=0, all req_wait=1; if any requester is eligible, latch grant index g, address, store data and direction, then go to BUSY next cycle.
REQ-020 BUSY: ramaddr, ramstore, ramREN and ramWEN are driven from the latched values; the RAM sees no change from the requester's live inputs.
REQ-021 BUSY completion: when ramstate==ACCESS, req_wait[g]=0 and req_load=ramload in that same cycle (combinational), ptr<=g+1 mod NREQ, and the FSM goes to IDLE.
REQ-022 BUSY error: when ramstate==ERROR, the behaviour is the same as completion and err_ram pulses.
REQ-023 Abort: when both req_ren[g] and req_wen[g] drop in BUSY, the FSM goes to IDLE, ptr is unchanged and req_wait[g] stays 1.
REQ-024 Every access is followed by at least one IDLE cycle; back-to-back accesses from one requester are therefore separated by one dead cycle.
REQ-025 Outside a completion cycle, req_load=0 and every req_wait=1.
REQ-026 Latency: with the RAM reaching ACCESS k cycles after the BUSY entry cycle, the requester sees req_wait=0 k+1 cycles after its request is first sampled in IDLE.

Reset
REQ-027 RST high forces, immediately and regardless of CLK, state=IDLE, ptr=0, grant=0, latched address/store=0, timeout counter=0, all enables and error pulses 0, all req_wait=1.
REQ-028 RST asserted during BUSY abandons the access with no completion pulse; arbitration restarts from index 0 after release.

Configuration
REQ-029 Macro RAM_ARB_TIMEOUT_EN: when defined, a counter clears on BUSY entry and increments each BUSY cycle; on reaching TIMEOUT_CYCLES without ACCESS or ERROR, req_wait[g]=0, req_load=32'hBAD1BAD1, err_timeout pulses, ptr advances, and the FSM goes to IDLE.
REQ-030 When RAM_ARB_TIMEOUT_EN is undefined there is no counter, err_timeout is tied to 0, and BUSY waits indefinitely.

Structure
REQ-031 word_t and ramstate_t come from cpu_types_pkg; arb_state_t (IDLE, BUSY) is added to cpu_types_pkg.
REQ-032 One combinational sub-module, rr_picker, takes the eligible vector and ptr and returns a valid flag and the winning index; ram_arbiter instantiates it once.

Verification
REQ-033 Single read: req_ren[1]=1, addr 0x100; RAM gives ACCESS on the 2nd BUSY cycle with ramload 0xDEADBEEF -> req_wait[1]=0 for exactly one cycle, req_load=0xDEADBEEF, ramREN=1 during BUSY only.
REQ-034 Fairness: all four requesters hold reads, RAM ACCESS after 1 cycle -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
REQ-035 Illegal request: req_ren[2]=req_wen[2]=1 while req_wen[3]=1 with addr 0x40, data 0x12345678 -> err_illegal high each cycle, requester 3 is granted, ramWEN=1, ramstore=0x12345678.
REQ-036 Abort and reset: requester 0 drops its request in BUSY -> IDLE next cycle, ptr stays 0; RST pulsed mid-BUSY -> ramREN=0 in the same cycle before the next CLK edge.
REQ-037 Timeout (macro defined, TIMEOUT_CYCLES=8): ramstate held at BUSY -> after 8 BUSY cycles req_wait[g]=0, req_load=0xBAD1BAD1, err_timeout=1 for one cycle; macro undefined -> FSM remains in BUSY.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM types: word width, RAM status codes and the arbiter FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter states carry a prefix so they cannot clash with ramstate_t's BUSY.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Read data returned to a requester whose access was abandoned by the watchdog.
  localparam word_t TIMEOUT_LOAD = 32'hBAD1BAD1;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first eligible index at or after ptr, wrapping to 0.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  int j;

  // Scan from the farthest offset down so the closest eligible index is written last.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      j = int'(ptr) + off;
      if (j >= NREQ) j = j - NREQ;
      if (eligible[IW'(j)]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ requesters.
// Optional BUSY watchdog enabled by defining RAM_ARB_TIMEOUT_EN.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic  [NREQ-1:0]   req_ren,
  input  logic  [NREQ-1:0]   req_wen,
  input  word_t [NREQ-1:0]   req_addr,
  input  word_t [NREQ-1:0]   req_store,
  output logic  [NREQ-1:0]   req_wait,
  output word_t              req_load,
  output word_t              ramaddr,
  output word_t              ramstore,
  output logic               ramREN,
  output logic               ramWEN,
  input  word_t              ramload,
  input  ramstate_t          ramstate,
  output logic               err_illegal,
  output logic               err_ram,
  output logic               err_timeout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t      state, state_nx;
  logic [IW-1:0]   ptr, ptr_nx;
  logic [IW-1:0]   gnt;
  word_t           lat_addr, lat_store;
  logic            lat_wen;
  logic [NREQ-1:0] eligible;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   gnt_next;

  // A requester asking for both directions at once is ignored and flagged.
  assign eligible    = req_ren ^ req_wen;
  assign err_illegal = ~RST & (|(req_ren & req_wen));
  assign gnt_next    = (gnt == IW'(NREQ - 1)) ? '0 : gnt + 1'b1;

  rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
    .eligible (eligible),
    .ptr      (ptr),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;
  logic          to_hit;

  // Count BUSY cycles; the count starts from zero on every BUSY entry.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                   to_cnt <= '0;
    else if (state == ARB_BUSY) to_cnt <= to_cnt + 1'b1;
    else                       to_cnt <= '0;
  end

  assign to_hit = (to_cnt == CW'(TIMEOUT_CYCLES));
`else
  logic to_hit;
  assign to_hit = 1'b0;
`endif

  // State, pointer and captured request; cleared asynchronously on RST.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      gnt       <= '0;
      lat_addr  <= '0;
      lat_store <= '0;
      lat_wen   <= 1'b0;
    end else begin
      // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
      state <= state_nx;
      ptr   <= ptr_nx;
      if (state == ARB_IDLE && pick_valid) begin
        gnt       <= pick_idx;
        lat_addr  <= req_addr[pick_idx];
        lat_store <= req_store[pick_idx];
        lat_wen   <= req_wen[pick_idx];
      end
    end
  end

  // Next-state logic and all RAM/requester outputs.
  always_comb begin
    state_nx    = state;
    ptr_nx      = ptr;
    req_wait    = '1;
    req_load    = '0;
    ramaddr     = '0;
    ramstore    = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    err_ram     = 1'b0;
    err_timeout = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_valid) state_nx = ARB_BUSY;
      end
      ARB_BUSY: begin
        ramaddr  = lat_addr;
        ramstore = lat_store;
        ramREN   = ~lat_wen;
        ramWEN   = lat_wen;
        if (ramstate == ACCESS || ramstate == ERROR) begin
          // A finished RAM access wins over a simultaneous request drop.
          req_wait[gnt] = 1'b0;
          req_load      = ramload;
          err_ram       = (ramstate == ERROR);
          ptr_nx        = gnt_next;
          state_nx      = ARB_IDLE;
        end else if (to_hit) begin
          req_wait[gnt] = 1'b0;
          req_load      = TIMEOUT_LOAD;
          err_timeout   = 1'b1;
          ptr_nx        = gnt_next;
          state_nx      = ARB_IDLE;
        end else if (!req_ren[gnt] && !req_wen[gnt]) begin
          state_nx = ARB_IDLE;
        end
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus random traffic,
// all outputs compared every cycle against a transaction-level model.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam int NREQ = 4;
  localparam int TO   = 8;

  logic               CLK = 1'b0;
  logic               RST;
  logic  [NREQ-1:0]   req_ren, req_wen, req_wait;
  word_t [NREQ-1:0]   req_addr, req_store;
  word_t              req_load, ramaddr, ramstore, ramload;
  logic               ramREN, ramWEN, err_illegal, err_ram, err_timeout;
  ramstate_t          ramstate;

  int n_vec = 0;
  int n_bad = 0;

  // Model state: one outstanding transaction at most.
  bit    m_busy;
  int    m_ptr, m_g, m_cyc;
  word_t m_addr, m_store;
  bit    m_wr;

  int    cyc = 0;
  int    done_q[$];
  int    done_t[$];
  word_t done_load[$];
  int    to_pulses;

  ram_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(TO)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .req_ren     (req_ren),
    .req_wen     (req_wen),
    .req_addr    (req_addr),
    .req_store   (req_store),
    .req_wait    (req_wait),
    .req_load    (req_load),
    .ramaddr     (ramaddr),
    .ramstore    (ramstore),
    .ramREN      (ramREN),
    .ramWEN      (ramWEN),
    .ramload     (ramload),
    .ramstate    (ramstate),
    .err_illegal (err_illegal),
    .err_ram     (err_ram),
    .err_timeout (err_timeout)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  task automatic clear_log();
    done_q.delete();
    done_t.delete();
    done_load.delete();
    to_pulses = 0;
  endtask

  task automatic idle_inputs();
    req_ren  = '0;
    req_wen  = '0;
    ramstate = FREE;
    ramload  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i]  = '0;
      req_store[i] = '0;
    end
  endtask

  // One clock cycle: called at a falling edge with inputs already applied.
  task automatic step(input string tag);
    logic [NREQ-1:0] e_wait;
    word_t e_load, e_addr, e_store;
    logic  e_ren, e_wen, e_ill, e_ram, e_to;
    bit    fin, tmo;
    int    k;
    e_wait = '1; e_load = '0; e_addr = '0; e_store = '0;
    e_ren = 0; e_wen = 0; e_ram = 0; e_to = 0; fin = 0; tmo = 0;
    e_ill = !RST && ((req_ren & req_wen) != '0);
    if (!RST && m_busy) begin
      e_addr  = m_addr;
      e_store = m_store;
      e_ren   = !m_wr;
      e_wen   = m_wr;
      if (ramstate == ACCESS || ramstate == ERROR) begin
        fin = 1; e_wait[m_g] = 1'b0; e_load = ramload; e_ram = (ramstate == ERROR);
      end
`ifdef RAM_ARB_TIMEOUT_EN
      else if (m_cyc == TO) begin
        tmo = 1; e_wait[m_g] = 1'b0; e_load = 32'hBAD1BAD1; e_to = 1;
      end
`endif
    end
    #1;
    check({tag, ".wait"},  32'(req_wait),    32'(e_wait));
    check({tag, ".load"},  req_load,         e_load);
    check({tag, ".addr"},  ramaddr,          e_addr);
    check({tag, ".store"}, ramstore,         e_store);
    check({tag, ".ren"},   32'(ramREN),      32'(e_ren));
    check({tag, ".wen"},   32'(ramWEN),      32'(e_wen));
    check({tag, ".eill"},  32'(err_illegal), 32'(e_ill));
    check({tag, ".eram"},  32'(err_ram),     32'(e_ram));
    check({tag, ".eto"},   32'(err_timeout), 32'(e_to));
    for (int i = 0; i < NREQ; i++)
      if (!req_wait[i]) begin
        done_q.push_back(i);
        done_t.push_back(cyc);
        done_load.push_back(req_load);
      end
    if (err_timeout) to_pulses++;
    cyc++;
    // Advance the model across the rising edge.
    if (RST) begin
      m_busy = 0; m_ptr = 0; m_g = 0; m_cyc = 0;
    end else if (m_busy) begin
      if (fin || tmo) begin
        m_ptr  = (m_g + 1) % NREQ;
        m_busy = 0;
      end else if (!req_ren[m_g] && !req_wen[m_g]) begin
        m_busy = 0;
      end else begin
        m_cyc++;
      end
    end else begin
      for (int off = 0; off < NREQ; off++) begin
        k = (m_ptr + off) % NREQ;
        if (!m_busy && (req_ren[k] ^ req_wen[k])) begin
          m_busy  = 1;
          m_g     = k;
          m_cyc   = 0;
          m_addr  = req_addr[k];
          m_store = req_store[k];
          m_wr    = req_wen[k];
        end
      end
    end
    @(negedge CLK);
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    step("reset");
    step("reset_hold");
    RST = 1'b0;
    clear_log();
  endtask

  task automatic check_first(input string tag, input int exp_idx);
    check({tag, ".count"}, 32'(done_q.size()), 32'd1);
    if (done_q.size() > 0) check({tag, ".who"}, 32'(done_q[0]), 32'(exp_idx));
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int r;

  initial begin
    m_busy = 0; m_ptr = 0; m_g = 0; m_cyc = 0; m_wr = 0;
    m_addr = '0; m_store = '0;
    clear_log();
    idle_inputs();
    RST = 1'b1;
    @(negedge CLK);
    do_reset();

    // Single read from requester 1, RAM answers on the second BUSY cycle.
    req_ren[1] = 1'b1; req_addr[1] = 32'h100;
    step("rd.idle");
    ramstate = BUSY;
    #1 check("rd.ren_b1", 32'(ramREN), 32'd1);
    check("rd.addr_b1", ramaddr, 32'h100);
    step("rd.b1");
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    #1 check("rd.wait1", 32'(req_wait[1]), 32'd0);
    check("rd.load", req_load, 32'hDEADBEEF);
    step("rd.b2");
    ramstate = FREE; req_ren[1] = 1'b0;
    #1 check("rd.ren_after", 32'(ramREN), 32'd0);
    step("rd.after");
    step("rd.after2");
    check_first("rd", 1);

    // Fairness: all four requesters reading, RAM completes on the first BUSY cycle.
    do_reset();
    req_ren = '1; ramstate = ACCESS; ramload = 32'h0BADF00D;
    repeat (10) step("fair");
    check("fair.count", 32'(done_q.size() >= 5), 32'd1);
    for (int k = 0; k < 5 && k < done_q.size(); k++)
      check("fair.order", 32'(done_q[k]), 32'(exp_order[k]));
    for (int k = 1; k < 5 && k < done_t.size(); k++)
      check("fair.gap", 32'(done_t[k] - done_t[k-1]), 32'd2);

    // Illegal requester 2 is skipped; requester 3 writes.
    do_reset();
    req_ren[2] = 1'b1; req_wen[2] = 1'b1;
    req_wen[3] = 1'b1; req_addr[3] = 32'h40; req_store[3] = 32'h12345678;
    #1 check("ill.err_idle", 32'(err_illegal), 32'd1);
    step("ill.idle");
    ramstate = BUSY;
    #1 check("ill.err_busy", 32'(err_illegal), 32'd1);
    check("ill.wen", 32'(ramWEN), 32'd1);
    check("ill.store", ramstore, 32'h12345678);
    check("ill.addr", ramaddr, 32'h40);
    step("ill.b1");
    ramstate = ACCESS;
    step("ill.b2");
    check_first("ill", 3);

    // Abort: requester 0 drops in BUSY; pointer stays at 0.
    do_reset();
    req_ren[0] = 1'b1;
    step("abt.idle");
    req_ren[0] = 1'b0;
    step("abt.drop");
    req_ren[0] = 1'b1; req_ren[1] = 1'b1;
    #1 check("abt.ren_idle", 32'(ramREN), 32'd0);
    step("abt.idle2");
    ramstate = ACCESS;
    step("abt.b1");
    check_first("abt", 0);

    // Reset mid-BUSY after the pointer has moved past 0.
    do_reset();
    req_ren[2] = 1'b1;
    step("rstb.idle");
    ramstate = ACCESS;
    step("rstb.done");
    ramstate = FREE;
    step("rstb.idle2");
    #1 check("rstb.ren_busy", 32'(ramREN), 32'd1);
    RST = 1'b1;
    #1 check("rstb.ren_async", 32'(ramREN), 32'd0);
    check("rstb.wait_async", 32'(req_wait), 32'hF);
    step("rstb.in_reset");
    RST = 1'b0; req_ren = 4'b1010;
    clear_log();
    step("rstb.idle3");
    ramstate = ACCESS;
    step("rstb.b1");
    check_first("rstb", 1);

    // RAM stuck in BUSY.
    do_reset();
    req_ren[0] = 1'b1;
    step("to.idle");
    ramstate = BUSY;
    repeat (15) step("to.busy");
`ifdef RAM_ARB_TIMEOUT_EN
    check("to.pulses", 32'(to_pulses), 32'd1);
    check_first("to", 0);
    if (done_load.size() > 0) check("to.load", done_load[0], 32'hBAD1BAD1);
`else
    #1 check("to.still_busy", 32'(ramREN), 32'd1);
    check("to.no_done", 32'(done_q.size()), 32'd0);
`endif

    // Random traffic against the model.
    do_reset();
    repeat (600) begin
      RST = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NREQ; i++) begin
        r = $urandom_range(0, 9);
        req_ren[i]   = (r >= 4 && r <= 6) || r == 9;
        req_wen[i]   = (r >= 7);
        req_addr[i]  = $urandom();
        req_store[i] = $urandom();
      end
      r = $urandom_range(0, 9);
      ramstate = (r <= 2) ? ACCESS : (r == 3) ? ERROR : (r <= 6) ? BUSY : FREE;
      ramload  = $urandom();
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
